// File: rtl/bram_output_readout_ctrl_if.sv
// AXI-Stream beat bundle between the readout sequencer and the DMA path.
// The master drives data/valid/last, the slave returns ready.
interface bram_output_readout_ctrl_if #(
    parameter int DW        = 16,
    parameter int NUM_BRAMS = 16
);
    logic [NUM_BRAMS*DW-1:0] tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/bram_output_readout_ctrl.sv
// Output BRAM readout sequencer: waits for accumulation to go quiet, takes the
// BRAM read ports and streams one 16-lane word per AXI-Stream beat.
module bram_output_readout_ctrl #(
    parameter int DW         = 16,
    parameter int NUM_BRAMS  = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int DRAIN_CYC  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            num_words,
    input  logic                           partial_valid,
    output logic                           ext_read_mode,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
    input  logic [NUM_BRAMS*DW-1:0]        bram_read_data_flat,
    bram_output_readout_ctrl_if.master     m_axis,
    output logic                           busy,
    output logic                           done
);

    localparam int CW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [ADDR_WIDTH:0]   ONE_W    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ADDR,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_cur_addr;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic [CW-1:0]           r_idle_cnt;
    logic [NUM_BRAMS*DW-1:0] r_tdata;

    logic                    w_load;
    logic                    w_cnt_clr;
    logic                    w_cnt_inc;
    logic                    w_capture;
    logic                    w_advance;
    logic [ADDR_WIDTH-1:0]   w_addr_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Takeover happens on the cycle that completes DRAIN_CYC quiet cycles
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (num_words == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (partial_valid) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (r_idle_cnt == CNT_LAST) begin
                        w_next = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                w_next = S_CAPT;
            end
            S_CAPT: begin
                w_capture = 1'b1;
                w_next    = S_SEND;
            end
            S_SEND: begin
                if (m_axis.tready) begin
                    w_advance = 1'b1;
                    if (r_remaining > ONE_W) begin
                        w_next = S_ADDR;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_addr_inc = (r_cur_addr == LAST_A) ? '0 : r_cur_addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else if (w_load) begin
            r_cur_addr  <= base_addr;
            r_remaining <= num_words;
        end else if (w_advance) begin
            r_cur_addr  <= w_addr_inc;
            r_remaining <= r_remaining - ONE_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_load || w_cnt_clr) begin
            r_idle_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata <= '0;
        end else if (w_capture) begin
            r_tdata <= bram_read_data_flat;
        end
    end

    assign ext_read_mode = (r_state == S_ADDR) ||
                           (r_state == S_CAPT) ||
                           (r_state == S_SEND);

    assign ext_read_addr_flat = {NUM_BRAMS{r_cur_addr}};

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = (r_state == S_SEND);
    assign m_axis.tlast  = (r_state == S_SEND) && (r_remaining == ONE_W);

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_bram_output_readout_ctrl.sv
// Bench for the BRAM readout sequencer: timing table, corner sequences and
// random transfers scored against a queue of expected beats.
module tb_bram_output_readout_ctrl;

    localparam int BOUND = 2000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [8:0]   base_addr = '0;
    logic [9:0]   num_words = '0;
    logic         partial_valid = 1'b0;
    logic         ext_read_mode;
    logic [143:0] ext_read_addr_flat;
    logic [255:0] bram_read_data_flat = '0;
    logic         busy;
    logic         done;

    int n_total = 0;
    int n_bad = 0;
    int beats = 0;
    int salt = 0;
    logic [255:0] exp_q[$];

    bram_output_readout_ctrl_if m_axis ();

    bram_output_readout_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .base_addr           (base_addr),
        .num_words           (num_words),
        .partial_valid       (partial_valid),
        .ext_read_mode       (ext_read_mode),
        .ext_read_addr_flat  (ext_read_addr_flat),
        .bram_read_data_flat (bram_read_data_flat),
        .m_axis              (m_axis),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    // Contents of lane i at address a
    function automatic logic [255:0] make_word(int a);
        logic [255:0] w;
        for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(i*256 + a + salt);
        return w;
    endfunction

    task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // BRAM array: one-cycle read latency, junk when not in external mode
    initial forever begin
        logic [255:0] tmp;
        @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            if (ext_read_mode)
                tmp[i*16 +: 16] = 16'(i*256 + int'(ext_read_addr_flat[i*9 +: 9]) + salt);
            else
                tmp[i*16 +: 16] = 16'hDEAD;
        end
        bram_read_data_flat <= tmp;
    end

    // Scoreboard and stall-stability monitor
    initial begin
        bit           prev_stall;
        logic [255:0] held_d;
        logic         held_l;
        prev_stall = 0;
        held_d = '0;
        held_l = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", m_axis.tvalid, 1'b1);
                    chk("stall_data", m_axis.tdata, held_d);
                    chk("stall_last", m_axis.tlast, held_l);
                end
                if (ext_read_mode)
                    chk("addr_repl", ext_read_addr_flat, {16{ext_read_addr_flat[8:0]}});
                if (m_axis.tvalid && m_axis.tready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL extra_beat got=%0h expected=none", m_axis.tdata);
                    end else begin
                        chk("beat_data", m_axis.tdata, exp_q[0]);
                        chk("beat_last", m_axis.tlast, logic'(exp_q.size() == 1));
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
                prev_stall = m_axis.tvalid && !m_axis.tready;
                held_d = m_axis.tdata;
                held_l = m_axis.tlast;
            end
        end
    end

    task automatic run_txn(input logic [8:0] b, input logic [9:0] nw,
                           input logic [63:0] pv_pat, input int stall_pct,
                           input bit stall5, input int restart_n,
                           output int e_n, output int v_n, output int d_n);
        int b0;
        int stalls;
        for (int k = 0; k < int'(nw); k++) exp_q.push_back(make_word((int'(b) + k) % 512));
        @(posedge clk); #1;
        base_addr = b;
        num_words = nw;
        start = 1'b1;
        partial_valid = 1'b0;
        m_axis.tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 9'($urandom);
        num_words = 10'($urandom);
        e_n = 0;
        v_n = 0;
        d_n = 0;
        stalls = 0;
        b0 = beats;
        for (int n = 1; n <= BOUND; n++) begin
            partial_valid = (n < 64) ? pv_pat[n] : 1'b0;
            start = (n == restart_n);
            if (n == restart_n) begin
                base_addr = b + 9'd50;
                num_words = 10'd3;
            end
            m_axis.tready = ($urandom_range(99) >= stall_pct);
            if (stall5 && (beats - b0 == 1) && stalls < 5) m_axis.tready = 1'b0;
            @(negedge clk);
            if (n == 1) chk("busy_rise", busy, 1'b1);
            if (stall5 && m_axis.tvalid && !m_axis.tready) stalls++;
            if (e_n == 0 && ext_read_mode) e_n = n;
            if (v_n == 0 && m_axis.tvalid) v_n = n;
            if (done) begin
                d_n = n;
                break;
            end
            @(posedge clk); #1;
        end
        if (d_n == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL done_timeout got=none expected=done within %0d", BOUND);
        end
        @(posedge clk); #1;
        start = 1'b0;
        partial_valid = 1'b0;
        m_axis.tready = 1'b1;
        @(negedge clk);
        chk("done_pulse_end", done, 1'b0);
        chk("busy_end", busy, 1'b0);
        chk("erm_end", ext_read_mode, 1'b0);
        chk("all_beats_sent", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_tvalid"}, m_axis.tvalid, 1'b0);
        chk({tag, "_tlast"}, m_axis.tlast, 1'b0);
        chk({tag, "_tdata"}, m_axis.tdata, '0);
        chk({tag, "_erm"}, ext_read_mode, 1'b0);
        chk({tag, "_addr"}, ext_read_addr_flat, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  num;
        logic [63:0] pv;
        bit          stall5;
        int          e_erm;
        int          e_tv;
        int          e_done;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int e_n, v_n, d_n;
        tbl[0] = '{9'd0,   10'd4,   64'h0, 1'b0, 5, 7, 17};
        tbl[1] = '{9'd510, 10'd4,   64'h0, 1'b0, 5, 7, 17};
        tbl[2] = '{9'd20,  10'd4,   64'h0, 1'b1, 5, 7, 22};
        tbl[3] = '{9'd7,   10'd3,   64'hA, 1'b0, 8, 10, 17};
        tbl[4] = '{9'd0,   10'd0,   64'h0, 1'b0, 0, 0, 1};
        tbl[5] = '{9'd100, 10'd1,   64'hE, 1'b0, 8, 10, 11};
        tbl[6] = '{9'd511, 10'd2,   64'h0, 1'b0, 5, 7, 11};
        tbl[7] = '{9'd5,   10'd512, 64'h0, 1'b0, 5, 7, 1541};

        m_axis.tready = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        salt = 0;
        for (int t = 0; t < 8; t++) begin
            run_txn(tbl[t].base, tbl[t].num, tbl[t].pv, 0, tbl[t].stall5, -1, e_n, v_n, d_n);
            chk($sformatf("tbl%0d_erm_cycle", t), e_n, tbl[t].e_erm);
            chk($sformatf("tbl%0d_tvalid_cycle", t), v_n, tbl[t].e_tv);
            chk($sformatf("tbl%0d_done_cycle", t), d_n, tbl[t].e_done);
        end

        // start while busy: mid-transfer and on the DONE cycle
        run_txn(9'd60, 10'd5, 64'h0, 0, 1'b0, 3, e_n, v_n, d_n);
        chk("restart_mid_done", d_n, 20);
        run_txn(9'd61, 10'd5, 64'h0, 0, 1'b0, 20, e_n, v_n, d_n);
        chk("restart_done_done", d_n, 20);
        @(negedge clk);
        chk("restart_no_accept", busy, 1'b0);

        // asynchronous reset while a beat is stalled
        @(posedge clk); #1;
        base_addr = 9'd40;
        num_words = 10'd8;
        start = 1'b1;
        m_axis.tready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 50 && !m_axis.tvalid; n++) @(negedge clk);
        chk("abort_in_send", m_axis.tvalid, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge clk); #2;
        rst_n = 1'b1;
        m_axis.tready = 1'b1;
        run_txn(9'd3, 10'd2, 64'h0, 0, 1'b0, -1, e_n, v_n, d_n);
        chk("post_rst_tvalid", v_n, 7);
        chk("post_rst_done", d_n, 11);

        // random transfers
        for (int r = 0; r < 15; r++) begin
            logic [8:0]  b;
            logic [9:0]  nw;
            logic [63:0] pv;
            salt = int'($urandom_range(0, 65535));
            b = 9'($urandom_range(0, 511));
            nw = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 24));
            pv = {$urandom, $urandom} & {$urandom, $urandom};
            run_txn(b, nw, pv, int'($urandom_range(0, 60)), 1'b0, -1, e_n, v_n, d_n);
            if (nw == 0) begin
                chk("rand_zero_done", d_n, 1);
                chk("rand_zero_erm", e_n, 0);
            end else begin
                chk("rand_erm_to_tvalid", v_n - e_n, 2);
                chk("rand_min_time", logic'(d_n >= e_n + 3*int'(nw)), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
